// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754-style floating-point divider: restoring mantissa division,
// round-to-nearest-even, special-operand handling and five exception flags.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         inexact,
  output logic         div_by_zero,
  output logic         invalid
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // start side transfers only in IDLE, result side holds result/flags until result_ready.
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_ROUND, S_DONE} state_t;

  localparam int CW = $clog2(MAN_W + 4);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAN_W + 3);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [EXP_W+1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] EMAX_X = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] ONE_X = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] ZERO_MAG = '0;

  state_t state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W+3:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EXP_W+1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     res_q, res_d;
  // flag order: {overflow, underflow, inexact, div_by_zero, invalid}
  logic [4:0]       flags_q, flags_d;

  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic zero1, zero2, inf1, inf2, nan1, nan2, is_special, sign_x;

  always_comb begin
    e1 = a_q[W-2:MAN_W];
    e2 = b_q[W-2:MAN_W];
    f1 = a_q[MAN_W-1:0];
    f2 = b_q[MAN_W-1:0];
    zero1 = (e1 == '0);
    zero2 = (e2 == '0);
    inf1 = (&e1) && (f1 == '0);
    inf2 = (&e2) && (f2 == '0);
    nan1 = (&e1) && (f1 != '0);
    nan2 = (&e2) && (f2 != '0);
    is_special = zero1 | zero2 | inf1 | inf2 | nan1 | nan2;
    sign_x = a_q[W-1] ^ b_q[W-1];
  end

  // Restoring divider step: subtract when the partial remainder covers the divisor.
  logic [MAN_W+1:0] m2x, rem_rest;
  logic             rem_ge;
  always_comb begin
    m2x = {2'b01, f2};
    rem_ge = (rem_q >= m2x);
    rem_rest = rem_ge ? (rem_q - m2x) : rem_q;
  end

  // Normalise, round to nearest even, then range-check the exponent.
  logic [MAN_W+2:0] qn;
  logic [EXP_W+1:0] e_n, e_f;
  logic [MAN_W:0]   frac_r;
  logic             guard, sticky, rnd_inc;
  always_comb begin
    qn = quo_q[MAN_W+3] ? quo_q[MAN_W+2:0] : {quo_q[MAN_W+1:0], 1'b0};
    e_n = quo_q[MAN_W+3] ? exp_q : (exp_q - ONE_X);
    guard = qn[2];
    sticky = qn[1] | qn[0] | (rem_q != '0);
    rnd_inc = guard & (sticky | qn[3]);
    frac_r = {1'b0, qn[MAN_W+2:3]} + {{MAN_W{1'b0}}, rnd_inc};
    e_f = e_n + {{(EXP_W+1){1'b0}}, frac_r[MAN_W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_valid) state_d = S_CHECK;
      S_CHECK: state_d = is_special ? S_DONE : S_DIV;
      S_DIV:   if (cnt_q == LAST_CNT) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == S_IDLE) && rst_n;
    result_valid = (state_q == S_DONE);
    result = res_q;
    {overflow, underflow, inexact, div_by_zero, invalid} = flags_q;
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    exp_d = exp_q;
    sign_d = sign_q;
    res_d = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (start_valid) begin
        a_d = num1;
        b_d = num2;
      end
      S_CHECK: begin
        sign_d = sign_x;
        rem_d = {2'b01, f1};
        quo_d = '0;
        cnt_d = '0;
        exp_d = {2'b00, e1} - {2'b00, e2} + BIAS_X;
        flags_d = '0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
          res_d = QNAN;
          flags_d = 5'b00001;
        end else if (inf1) begin
          res_d = {sign_x, INF_MAG};
        end else if (zero2) begin
          res_d = {sign_x, INF_MAG};
          flags_d = 5'b00010;
        end else if (zero1 || inf2) begin
          res_d = {sign_x, ZERO_MAG};
        end
      end
      S_DIV: begin
        quo_d = {quo_q[MAN_W+2:0], rem_ge};
        rem_d = rem_rest << 1;
        cnt_d = cnt_q + CNT_ONE;
      end
      S_ROUND: begin
        if (!e_f[EXP_W+1] && (e_f >= EMAX_X)) begin
          res_d = {sign_q, INF_MAG};
          flags_d = 5'b10100;
        end else if (e_f[EXP_W+1] || (e_f == '0)) begin
          res_d = {sign_q, ZERO_MAG};
          flags_d = 5'b01100;
        end else begin
          res_d = {sign_q, e_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
          flags_d = {2'b00, guard | sticky, 2'b00};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      res_q <= res_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: single-precision and half-precision instances,
// hand-computed quotients, flags, latencies, handshake hold and mid-operation reset.
module tb_fp_div_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int tests = 0;
  int fails = 0;

  logic        sv_a, sr_a, rv_a, rr_a, ov_a, un_a, ix_a, dz_a, iv_a;
  logic [31:0] n1_a, n2_a, res_a;
  logic [4:0]  fl_a;
  assign fl_a = {ov_a, un_a, ix_a, dz_a, iv_a};

  logic        sv_h, sr_h, rv_h, rr_h, ov_h, un_h, ix_h, dz_h, iv_h;
  logic [15:0] n1_h, n2_h, res_h;
  logic [4:0]  fl_h;
  assign fl_h = {ov_h, un_h, ix_h, dz_h, iv_h};

  fp_div_seq dut_s (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_a), .start_ready(sr_a),
    .num1(n1_a), .num2(n2_a), .result_valid(rv_a), .result_ready(rr_a),
    .result(res_a), .overflow(ov_a), .underflow(un_a), .inexact(ix_a),
    .div_by_zero(dz_a), .invalid(iv_a)
  );

  fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_h), .start_ready(sr_h),
    .num1(n1_h), .num2(n2_h), .result_valid(rv_h), .result_ready(rr_h),
    .result(res_h), .overflow(ov_h), .underflow(un_h), .inexact(ix_h),
    .div_by_zero(dz_h), .invalid(iv_h)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags are {overflow, underflow, inexact, div_by_zero, invalid}.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic [4:0] exp_f,
                      input int exp_lat, input int hold);
    int lat;
    logic busy_ok;
    @(negedge clk);
    chk({tag, "_start_ready"}, sr_a, 1);
    sv_a = 1'b1; n1_a = a; n2_a = b;
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    sv_a = 1'b0; n1_a = '0; n2_a = '0;
    while (!rv_a && lat < 200) begin
      if (sr_a) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy"}, busy_ok, 1);
    chk({tag, "_result"}, res_a, exp_r);
    chk({tag, "_flags"}, fl_a, exp_f);
    for (int i = 0; i < hold; i++) begin
      sv_a = 1'b1; n1_a = $urandom; n2_a = $urandom;
      @(posedge clk);
      @(negedge clk);
      sv_a = 1'b0;
      chk({tag, "_hold_valid"}, rv_a, 1);
      chk({tag, "_hold_result"}, res_a, exp_r);
      chk({tag, "_hold_flags"}, fl_a, exp_f);
    end
    rr_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr_a = 1'b0;
    chk({tag, "_released"}, rv_a, 0);
    chk({tag, "_idle"}, sr_a, 1);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_r, input logic [4:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_start_ready"}, sr_h, 1);
    sv_h = 1'b1; n1_h = a; n2_h = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    sv_h = 1'b0;
    while (!rv_h && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, res_h, exp_r);
    chk({tag, "_flags"}, fl_h, exp_f);
    rr_h = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr_h = 1'b0;
    chk({tag, "_idle"}, sr_h, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    sv_a = 1'b0; rr_a = 1'b0; n1_a = '0; n2_a = '0;
    sv_h = 1'b0; rr_h = 1'b0; n1_h = '0; n2_h = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", res_a, 0);
    chk("rst_flags", fl_a, 0);
    chk("rst_valid", rv_a, 0);
    chk("rst_ready_low", sr_a, 0);
    chk("rst_half_result", res_h, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_high", sr_a, 1);

    op32("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 30, 0);
    op32("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00100, 30, 0);
    op32("three_by_one", 32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 30, 0);
    op32("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 30, 0);
    op32("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b00010, 2, 0);
    op32("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b00001, 2, 0);
    op32("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b00001, 2, 0);
    op32("neg_one_by_inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 2, 0);
    op32("nan_by_one", 32'hFFC00001, 32'h3F800000, 32'h7FC00000, 5'b00001, 2, 0);
    op32("neg_inf_by_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2, 0);
    op32("subnorm_by_one", 32'h00000001, 32'hBF800000, 32'h80000000, 5'b00000, 2, 0);
    op32("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b10100, 30, 0);
    op32("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b01100, 30, 0);
    op32("hold_done", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00100, 30, 10);

    // Abort an operation partway through the divide iterations.
    @(negedge clk);
    sv_a = 1'b1; n1_a = 32'h40C00000; n2_a = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    sv_a = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", sr_a, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_result", res_a, 0);
    chk("mid_rst_flags", fl_a, 0);
    chk("mid_rst_valid", rv_a, 0);
    chk("mid_rst_ready_low", sr_a, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready_high", sr_a, 1);
    op32("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 30, 0);

    op16("half_six_by_two", 16'h4600, 16'h4000, 16'h4200, 5'b00000, 17);
    op16("half_one_by_three", 16'h3C00, 16'h4200, 16'h3555, 5'b00100, 17);
    op16("half_one_by_zero", 16'h3C00, 16'h0000, 16'h7C00, 5'b00010, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
Multi-cycle, parametrised IEEE-754-style floating-point divider for the FPU path. It is the sequential successor of the combinational single-precision divider. It adds generic exponent/mantissa widths, a valid/ready handshake on both sides, an iterative restoring mantissa divider, round-to-nearest-even, and full special-operand handling with five exception flags. It sits between the coprocessor-1 operand latch and the FP writeback mux.

Parameters:
EXP_W, 8, exponent field width (8 = single, 5 = half, 11 = double)
MAN_W, 23, stored fraction width (hidden bit excluded)
(derived) W = 1+EXP_W+MAN_W total word width; BIAS = 2^(EXP_W-1)-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start_valid  in  1  operands valid
start_ready  out  1  divider idle, can accept operands
num1  in  W  dividend
num2  in  W  divisor
result_valid  out  1  result and flags valid
result_ready  in  1  consumer accepts result
result  out  W  quotient
overflow  out  1  rounded exponent too large, result = signed inf
underflow  out  1  result below min normal, flushed to signed zero
inexact  out  1  rounded result differs from exact quotient
div_by_zero  out  1  finite nonzero / zero
invalid  out  1  NaN operand, 0/0 or inf/inf

Behaviour:
- Reset (rst_n low at a clk edge): state goes to IDLE; result, all flags and result_valid go to 0; any operation in flight is discarded. start_ready is 0 while rst_n is low.
- start_ready = (state==IDLE). An operation is accepted on an edge where start_valid && start_ready; num1/num2 are registered on that edge. Inputs are ignored in all other states.
- FSM states: IDLE, CHECK, DIV, ROUND, DONE.
  - IDLE -> CHECK on accept.
  - CHECK (1 cycle): unpack and classify operands. Special case -> DONE. Otherwise -> DIV.
  - DIV: exactly MAN_W+4 cycles, then -> ROUND.
  - ROUND (1 cycle) -> DONE.
  - DONE: result_valid = 1. Go to IDLE on the edge where result_ready = 1. A new accept is possible no earlier than the following cycle.
- Latency from the accept edge to result_valid high: 2 edges for special cases, MAN_W+7 edges for normal operands (30 for defaults).
- Outputs are registered and stay stable in DONE regardless of inputs until the handshake completes.
- Subnormal inputs (exp==0) are treated as signed zero. Sign = num1 MSB ^ num2 MSB for every non-NaN result.
- Special-case priority, highest first:
  1. Any NaN, 0/0, or inf/inf -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1.
  2. inf/x -> signed inf.
  3. x/0 with x finite nonzero -> signed inf, div_by_zero=1.
  4. 0/x or x/inf -> signed zero.
  - All other flags are 0 in special cases.
- Normal path:
  - m1 = {1,frac1}, m2 = {1,frac2}.
  - Restoring division, one quotient bit per DIV cycle, MSB first. This yields q[MAN_W+3:0], with bit weights 2^0 down to 2^-(MAN_W+3).
  - sticky = (final remainder != 0).
  - Exponent is computed in EXP_W+2-bit signed arithmetic: e = e1 - e2 + BIAS.
  - If q MSB = 0: shift q left 1 and decrement e.
  - Fraction = next MAN_W bits after the leading 1. Guard = following bit. Sticky' = remaining bit OR sticky.
  - RNE: increment if guard && (sticky' || fraction LSB). Fraction carry-out increments e and zeroes the fraction.
  - inexact = guard || sticky'.
  - If final e >= 2^EXP_W-1: signed inf, overflow=1, inexact=1.
  - If final e <= 0: signed zero, underflow=1, inexact=1. There is no subnormal output.

Test Plan:
- Default params: 6.0/2.0 (0x40C00000 / 0x40000000) -> 0x40400000, all flags 0, result_valid exactly 30 edges after accept, start_ready low throughout.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB, inexact=1 (RNE round-up). 3.0/1.0 -> 0x40400000, inexact=0.
- Specials, each with 2-edge latency:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
  - 0/0 -> 0x7FC00000, invalid=1.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000, invalid=1.
  - 0xBF800000 / 0x7F800000 -> 0x80000000.
- Range:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow=1, inexact=1.
- Handshake and reset:
  - Hold result_ready low for 10 cycles in DONE: result and flags stay constant, start_valid pulses are ignored. Release: IDLE next cycle.
  - Drop rst_n 10 cycles into DIV: all outputs 0, start_ready 1 after release, next operation correct.
- EXP_W=5, MAN_W=10: 0x4600 / 0x4000 -> 0x4200, latency 17 edges; 0x3C00 / 0x4200 -> 0x3555, inexact=1.
